// File: rtl/instruction_decoder_stage_pkg.sv
// Shared decoder types: instruction format codes, base opcodes and the
// opcode-to-format classifier used by the decoder stage.
package decoder_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_INV = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Compressed encodings (low bits != 2'b11) are not handled by this stage.
  function automatic fmt_e decode_fmt(input logic [6:0] op_code);
    fmt_e f;
    f = FMT_INV;
    if (op_code[1:0] == 2'b11) begin
      case (op_code)
        OP_REG, OP_REG32:                                 f = FMT_R;
        OP_IMM, OP_IMM32, OP_LOAD, OP_JALR, OP_SYSTEM:    f = FMT_I;
        OP_STORE:                                         f = FMT_S;
        OP_BRANCH:                                        f = FMT_B;
        OP_LUI, OP_AUIPC:                                 f = FMT_U;
        OP_JAL:                                           f = FMT_J;
        default:                                          f = FMT_INV;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/instruction_decoder_stage_imm_gen.sv
// Combinational immediate builder: assembles the per-format immediate and
// sign-extends it from instruction[31] to WORDSIZE.
module imm_gen
  import decoder_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  logic [31:0]         instruction,
  input  fmt_e                fmt,
  output logic [WORDSIZE-1:0] imm
);

  logic [31:0] imm32;
  logic        unused_opcode_bits;

  assign unused_opcode_bits = ^instruction[6:0];

  always_comb begin
    imm32 = 32'd0;
    case (fmt)
      FMT_I: imm32 = {{20{instruction[31]}}, instruction[31:20]};
      FMT_S: imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      FMT_B: imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
      FMT_U: imm32 = {instruction[31:12], 12'd0};
      FMT_J: imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  // imm32 is already sign-extended to 32 bits; widen by replicating its MSB.
  always_comb begin
    imm       = {WORDSIZE{imm32[31]}};
    imm[31:0] = imm32;
  end

endmodule

// File: rtl/instruction_decoder_stage.sv
// Registered RV decoder stage with valid/ready on both sides and sync flush.
// Define INSTR_DECODER_ILLEGAL_CHECK_EN to drive the illegal flag.
module instruction_decoder_stage
  import decoder_pkg::*;
#(
  parameter int WORDSIZE = 64,
  parameter int SIZE     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SIZE-1:0]     instruction,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [6:0]          funct7,
  output logic [4:0]          rs2,
  output logic [4:0]          rs1,
  output logic [4:0]          rd,
  output logic [2:0]          funct3,
  output logic [6:0]          op_code,
  output logic [2:0]          fmt,
  output logic [WORDSIZE-1:0] imm,
  output logic                illegal
);

  logic                out_valid_reg;
  logic [6:0]          funct7_reg, op_code_reg;
  logic [4:0]          rs2_reg, rs1_reg, rd_reg;
  logic [2:0]          funct3_reg;
  fmt_e                fmt_reg;
  logic [WORDSIZE-1:0] imm_reg;

  fmt_e                fmt_next;
  logic [4:0]          rs2_next, rs1_next, rd_next;
  logic [WORDSIZE-1:0] imm_next;
  logic                transfer;

  assign in_ready = !flush && (!out_valid_reg || out_ready);
  assign transfer = in_valid && in_ready;

  assign fmt_next = decode_fmt(instruction[6:0]);

  // Unused register slots read as x0; INV keeps raw fields for debug.
  always_comb begin
    rd_next  = instruction[11:7];
    rs1_next = instruction[19:15];
    rs2_next = instruction[24:20];
    case (fmt_next)
      FMT_I:        rs2_next = 5'd0;
      FMT_S, FMT_B: rd_next  = 5'd0;
      FMT_U, FMT_J: begin
        rs1_next = 5'd0;
        rs2_next = 5'd0;
      end
      default: ;
    endcase
  end

  imm_gen #(
    .WORDSIZE(WORDSIZE)
  ) u_imm_gen (
    .instruction(instruction[31:0]),
    .fmt        (fmt_next),
    .imm        (imm_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      funct7_reg    <= '0;
      rs2_reg       <= '0;
      rs1_reg       <= '0;
      rd_reg        <= '0;
      funct3_reg    <= '0;
      op_code_reg   <= '0;
      fmt_reg       <= FMT_R;
      imm_reg       <= '0;
    end else begin
      if (transfer) begin
        out_valid_reg <= 1'b1;
        funct7_reg    <= instruction[31:25];
        rs2_reg       <= rs2_next;
        rs1_reg       <= rs1_next;
        rd_reg        <= rd_next;
        funct3_reg    <= instruction[14:12];
        op_code_reg   <= instruction[6:0];
        fmt_reg       <= fmt_next;
        imm_reg       <= imm_next;
      end else if (flush || out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

`ifdef INSTR_DECODER_ILLEGAL_CHECK_EN
  logic illegal_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_reg <= 1'b0;
    end else if (transfer) begin
      illegal_reg <= (fmt_next == FMT_INV);
    end
  end

  assign illegal = illegal_reg;
`else
  assign illegal = 1'b0;
`endif

  assign out_valid = out_valid_reg;
  assign funct7    = funct7_reg;
  assign rs2       = rs2_reg;
  assign rs1       = rs1_reg;
  assign rd        = rd_reg;
  assign funct3    = funct3_reg;
  assign op_code   = op_code_reg;
  assign fmt       = fmt_reg;
  assign imm       = imm_reg;

endmodule

// File: tb/tb_instruction_decoder_stage.sv
// Bench for instruction_decoder_stage: directed steps plus random traffic
// checked against a format-rule reference model.
module tb_instruction_decoder_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  funct7;
  logic [4:0]  rs2, rs1, rd;
  logic [2:0]  funct3;
  logic [6:0]  op_code;
  logic [2:0]  fmt;
  logic [63:0] imm;
  logic        illegal;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [6:0]  funct7;
    logic [4:0]  rs2, rs1, rd;
    logic [2:0]  funct3;
    logic [6:0]  op;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic        ill;
  } dec_t;

  dec_t exp_q;
  logic exp_valid;

  instruction_decoder_stage #(.WORDSIZE(64), .SIZE(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .instruction(instruction), .out_valid(out_valid),
    .out_ready(out_ready), .funct7(funct7), .rs2(rs2), .rs1(rs1), .rd(rd),
    .funct3(funct3), .op_code(op_code), .fmt(fmt), .imm(imm), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic dec_t model_decode(input logic [31:0] ins);
    dec_t   d;
    longint v;
    logic [6:0] op;
    op = ins[6:0];
    if (ins[1:0] != 2'b11) d.fmt = 3'd7;
    else if (op == 7'h33 || op == 7'h3B) d.fmt = 3'd0;
    else if (op == 7'h13 || op == 7'h1B || op == 7'h03 || op == 7'h67 || op == 7'h73) d.fmt = 3'd1;
    else if (op == 7'h23) d.fmt = 3'd2;
    else if (op == 7'h63) d.fmt = 3'd3;
    else if (op == 7'h37 || op == 7'h17) d.fmt = 3'd4;
    else if (op == 7'h6F) d.fmt = 3'd5;
    else d.fmt = 3'd7;
    v = 0;
    case (d.fmt)
      3'd1: v = longint'(ins[30:20]) - (ins[31] ? 2048 : 0);
      3'd2: v = longint'(ins[30:25]) * 32 + longint'(ins[11:7]) - (ins[31] ? 2048 : 0);
      3'd3: v = longint'(ins[11:8]) * 2 + longint'(ins[30:25]) * 32 + longint'(ins[7]) * 2048
                - (ins[31] ? 4096 : 0);
      3'd4: v = longint'(ins[30:12]) * 4096 - (ins[31] ? 64'sd2147483648 : 0);
      3'd5: v = longint'(ins[30:21]) * 2 + longint'(ins[20]) * 2048 + longint'(ins[19:12]) * 4096
                - (ins[31] ? 1048576 : 0);
      default: v = 0;
    endcase
    d.imm    = 64'(v);
    d.funct7 = ins[31:25];
    d.funct3 = ins[14:12];
    d.op     = op;
    d.rd     = (d.fmt == 3'd2 || d.fmt == 3'd3) ? 5'd0 : ins[11:7];
    d.rs1    = (d.fmt == 3'd4 || d.fmt == 3'd5) ? 5'd0 : ins[19:15];
    d.rs2    = (d.fmt == 3'd1 || d.fmt == 3'd4 || d.fmt == 3'd5) ? 5'd0 : ins[24:20];
`ifdef INSTR_DECODER_ILLEGAL_CHECK_EN
    d.ill    = (d.fmt == 3'd7);
`else
    d.ill    = 1'b0;
`endif
    return d;
  endfunction

  task automatic model_reset();
    exp_valid = 1'b0;
    exp_q = '{funct7: 7'd0, rs2: 5'd0, rs1: 5'd0, rd: 5'd0, funct3: 3'd0,
              op: 7'd0, fmt: 3'd0, imm: 64'd0, ill: 1'b0};
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("funct7", 64'(funct7), 64'(exp_q.funct7));
    chk("rs2", 64'(rs2), 64'(exp_q.rs2));
    chk("rs1", 64'(rs1), 64'(exp_q.rs1));
    chk("rd", 64'(rd), 64'(exp_q.rd));
    chk("funct3", 64'(funct3), 64'(exp_q.funct3));
    chk("op_code", 64'(op_code), 64'(exp_q.op));
    chk("fmt", 64'(fmt), 64'(exp_q.fmt));
    chk("imm", imm, exp_q.imm);
    chk("illegal", 64'(illegal), 64'(exp_q.ill));
  endtask

  // One clock: drive, check in_ready before the edge, then check registered outputs.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    logic rdy_exp;
    in_valid    = v;
    instruction = ins;
    out_ready   = ordy;
    flush       = fl;
    #3;
    rdy_exp = !fl && (!exp_valid || ordy);
    chk("in_ready", 64'(in_ready), 64'(rdy_exp));
    @(posedge clk);
    #1;
    if (v && rdy_exp) begin
      exp_q = model_decode(ins);
      exp_valid = 1'b1;
    end else if (fl || ordy) begin
      exp_valid = 1'b0;
    end
    check_all();
    $display("cyc v=%0d ins=%h ordy=%0d fl=%0d -> ov=%0d fmt=%0d imm=%h", v, ins, ordy, fl,
             out_valid, fmt, imm);
  endtask

  initial begin
    logic [31:0] r;
    logic [6:0]  ops [12];
    ops = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instruction = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 chk("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Basic R-type and immediate formats
    cycle(1'b1, 32'h00260233, 1'b1, 1'b0);
    chk("add_rd", 64'(rd), 64'd4);
    chk("add_rs1", 64'(rs1), 64'd12);
    chk("add_rs2", 64'(rs2), 64'd2);
    cycle(1'b1, 32'hFFF00093, 1'b1, 1'b0);
    chk("addi_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
    cycle(1'b1, 32'h123452B7, 1'b1, 1'b0);
    chk("lui_imm", imm, 64'h0000_0000_1234_5000);
    cycle(1'b1, 32'hFE000EE3, 1'b1, 1'b0);
    chk("beq_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_fmt", 64'(fmt), 64'd3);

    // Backpressure: A loads, B waits 4 cycles, then B and C flow back to back
    cycle(1'b1, 32'h00A00513, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h00B12023, 1'b0, 1'b0);
    cycle(1'b1, 32'h00B12023, 1'b1, 1'b0);
    chk("bp_second_op", 64'(op_code), 64'h23);
    cycle(1'b1, 32'h0080006F, 1'b1, 1'b0);
    chk("bp_third_op", 64'(op_code), 64'h6F);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush while full with a new instruction offered
    cycle(1'b1, 32'h00C00593, 1'b0, 1'b0);
    cycle(1'b1, 32'h12345637, 1'b1, 1'b1);
    chk("flush_drop_op", 64'(op_code), 64'h13);

    // Illegal encodings
    cycle(1'b1, 32'h00000000, 1'b1, 1'b0);
    chk("inv0_fmt", 64'(fmt), 64'd7);
    cycle(1'b1, 32'h0000007F, 1'b1, 1'b0);
    chk("inv7f_fmt", 64'(fmt), 64'd7);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      logic v, ordy, fl;
      r = $urandom();
      if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 11)];
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 15) == 0);
      cycle(v, r, ordy, fl);
    end

    // Reset mid-stream, asynchronous
    cycle(1'b1, 32'hFFF00093, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #1 chk("in_ready_after_midreset", 64'(in_ready), 64'd1);
    cycle(1'b1, 32'h00260233, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
